// File: rtl/tlb_array.sv
// tlb_array: fully associative LoongArch TLB storage with two search ports.
// Port 0 serves instruction fetch. Port 1 serves data accesses and TLBSRCH.
// The array also takes TLBWR/TLBFILL writes, TLBRD reads and INVTLB.
//
// Build option TLB_SEARCH_REG_EN:
//   defined   - each port keeps a registered result, tagged with the request
//               that produced it. ok rises one cycle after a new request.
//   undefined - results are combinational from the array, and ok == valid.

package tlb_array_pkg;
  localparam int TLB_IDX_W = 4;

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic                 found;
    logic [TLB_IDX_W-1:0] index;
    logic [19:0]          ppn;
    logic [5:0]           ps;
    logic [1:0]           plv;
    logic [1:0]           mat;
    logic                 d;
    logic                 v;
  } tlb_result_t;
endpackage

module tlb_array
  import tlb_array_pkg::*;
#(
  parameter int TLBNUM   = 16,
  parameter int TLBIDLEN = 4
) (
  input  logic                clk,
  input  logic                reset,
  // search port 0 (instruction)
  input  logic [18:0]         s0_vppn,
  input  logic                s0_va_bit12,
  input  logic [9:0]          s0_asid,
  input  logic                s0_valid,
  output tlb_result_t         s0_result,
  output logic                s0_ok,
  // search port 1 (data / TLBSRCH)
  input  logic [18:0]         s1_vppn,
  input  logic                s1_va_bit12,
  input  logic [9:0]          s1_asid,
  input  logic                s1_valid,
  output tlb_result_t         s1_result,
  output logic                s1_ok,
  // INVTLB command
  input  logic                invtlb_valid,
  input  logic [4:0]          invtlb_op,
  input  logic [9:0]          invtlb_asid,
  input  logic [31:0]         invtlb_va,
  // entry write
  input  logic                we,
  input  logic [TLBIDLEN-1:0] w_index,
  input  tlb_entry_t          w_entry,
  // entry read
  input  logic [TLBIDLEN-1:0] r_index,
  output tlb_entry_t          r_entry
);

  localparam logic [5:0] PS_2M = 6'd21;

  // Request/response handshake of a search port:
  //   The requester holds valid high with stable vppn/va_bit12/asid.
  //   ok is high in every cycle where result belongs to exactly the
  //   request now on the inputs. ok is combinational from valid and the
  //   inputs, so it drops in the same cycle the request goes away or
  //   changes. result is meaningful only while ok is high.

  tlb_entry_t mem [TLBNUM];

  // Per-port copies of the request inputs, so both ports share one code path.
  logic [18:0] q_vppn  [2];
  logic        q_bit12 [2];
  logic [9:0]  q_asid  [2];
  logic        q_valid [2];

  assign q_vppn[0]  = s0_vppn;
  assign q_vppn[1]  = s1_vppn;
  assign q_bit12[0] = s0_va_bit12;
  assign q_bit12[1] = s1_va_bit12;
  assign q_asid[0]  = s0_asid;
  assign q_asid[1]  = s1_asid;
  assign q_valid[0] = s0_valid;
  assign q_valid[1] = s1_valid;

  // The low 13 VA bits play no part in an INVTLB address compare.
  logic unused_va_low;
  assign unused_va_low = ^invtlb_va[12:0];

  // The page size sets how much of vppn is compared. A 2 MB page ignores vppn[8:0].
  function automatic logic vppn_match(input tlb_entry_t ent, input logic [18:0] vppn);
    if (ent.ps == PS_2M) return ent.vppn[18:9] == vppn[18:9];
    else                 return ent.vppn == vppn;
  endfunction

  logic [1:0][TLBNUM-1:0] hit;
  logic [1:0][TLBNUM-1:0] sel_odd;
  tlb_result_t            lk_res [2];
  logic [TLBNUM-1:0]      inv_hit;

  // Per-entry match and odd/even page choice for each search port.
  always_comb begin
    hit     = '0;
    sel_odd = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < TLBNUM; i++) begin
        hit[p][i] = mem[i].e &&
                    (mem[i].g || (mem[i].asid == q_asid[p])) &&
                    vppn_match(mem[i], q_vppn[p]);
        sel_odd[p][i] = (mem[i].ps == PS_2M) ? q_vppn[p][8] : q_bit12[p];
      end
    end
  end

  // Priority select. The scan runs from high to low so the lowest hit index wins.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      lk_res[p] = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
        if (hit[p][i]) begin
          lk_res[p].found = 1'b1;
          lk_res[p].index = TLB_IDX_W'(i);
          lk_res[p].ps    = mem[i].ps;
          lk_res[p].ppn   = sel_odd[p][i] ? mem[i].ppn1 : mem[i].ppn0;
          lk_res[p].plv   = sel_odd[p][i] ? mem[i].plv1 : mem[i].plv0;
          lk_res[p].mat   = sel_odd[p][i] ? mem[i].mat1 : mem[i].mat0;
          lk_res[p].d     = sel_odd[p][i] ? mem[i].d1   : mem[i].d0;
          lk_res[p].v     = sel_odd[p][i] ? mem[i].v1   : mem[i].v0;
        end
      end
    end
  end

  // INVTLB kill vector, computed for every entry in parallel from the op code.
  always_comb begin
    inv_hit = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      case (invtlb_op)
        5'd0, 5'd1: inv_hit[i] = 1'b1;
        5'd2:       inv_hit[i] = mem[i].g;
        5'd3:       inv_hit[i] = !mem[i].g;
        5'd4:       inv_hit[i] = !mem[i].g && (mem[i].asid == invtlb_asid);
        5'd5:       inv_hit[i] = !mem[i].g && (mem[i].asid == invtlb_asid) &&
                                 vppn_match(mem[i], invtlb_va[31:13]);
        5'd6:       inv_hit[i] = (mem[i].g || (mem[i].asid == invtlb_asid)) &&
                                 vppn_match(mem[i], invtlb_va[31:13]);
        default:    inv_hit[i] = 1'b0;
      endcase
    end
  end

  // Entry storage. A write to an index takes priority over an INVTLB in the same cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < TLBNUM; i++) begin
      if (reset) begin
        mem[i] <= '0;
      end else if (we && (w_index == TLBIDLEN'(i))) begin
        mem[i] <= w_entry;
      end else if (invtlb_valid && inv_hit[i]) begin
        mem[i].e <= 1'b0;
      end
    end
  end

  assign r_entry = mem[r_index];

`ifdef TLB_SEARCH_REG_EN
  logic [18:0] tag_vppn  [2];
  logic        tag_bit12 [2];
  logic [9:0]  tag_asid  [2];
  logic        rvalid    [2];
  tlb_result_t res_q     [2];
  logic        tag_eq    [2];
  logic        port_ok   [2];

  // The held result serves the presented request only if its tag matches.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      tag_eq[p]  = (tag_vppn[p] == q_vppn[p]) && (tag_bit12[p] == q_bit12[p]) &&
                   (tag_asid[p] == q_asid[p]);
      port_ok[p] = q_valid[p] && rvalid[p] && tag_eq[p];
    end
  end

  // Result registers. Any array update makes both held results stale and
  // drops a lookup made in the same cycle.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (reset) begin
        rvalid[p]    <= 1'b0;
        tag_vppn[p]  <= '0;
        tag_bit12[p] <= 1'b0;
        tag_asid[p]  <= '0;
        res_q[p]     <= '0;
      end else if (we || invtlb_valid) begin
        rvalid[p] <= 1'b0;
      end else if (q_valid[p] && !(rvalid[p] && tag_eq[p])) begin
        tag_vppn[p]  <= q_vppn[p];
        tag_bit12[p] <= q_bit12[p];
        tag_asid[p]  <= q_asid[p];
        res_q[p]     <= lk_res[p];
        rvalid[p]    <= 1'b1;
      end
    end
  end

  assign s0_result = res_q[0];
  assign s1_result = res_q[1];
  assign s0_ok     = port_ok[0];
  assign s1_ok     = port_ok[1];
`else
  // Combinational search: the answer is ready in the same cycle as the request.
  assign s0_result = lk_res[0];
  assign s1_result = lk_res[1];
  assign s0_ok     = s0_valid;
  assign s1_ok     = s1_valid;
`endif

endmodule

// File: tb/tb_tlb_array.sv
// Testbench for tlb_array: directed scenarios plus randomized traffic,
// checked against a behavioural TLB model through per-port expected queues.
// Works with TLB_SEARCH_REG_EN defined or undefined.

module tb_tlb_array;
  import tlb_array_pkg::*;

  localparam int RW = $bits(tlb_result_t);
`ifdef TLB_SEARCH_REG_EN
  localparam bit REG_MODE = 1'b1;
`else
  localparam bit REG_MODE = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [18:0] s0_vppn, s1_vppn;
  logic        s0_va_bit12, s1_va_bit12;
  logic [9:0]  s0_asid, s1_asid;
  logic        s0_valid, s1_valid;
  tlb_result_t s0_result, s1_result;
  logic        s0_ok, s1_ok;
  logic        invtlb_valid;
  logic [4:0]  invtlb_op;
  logic [9:0]  invtlb_asid;
  logic [31:0] invtlb_va;
  logic        we;
  logic [3:0]  w_index;
  tlb_entry_t  w_entry;
  logic [3:0]  r_index;
  tlb_entry_t  r_entry;

  tlb_array #(.TLBNUM(16), .TLBIDLEN(4)) dut (
    .clk(clk), .reset(reset),
    .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
    .s0_valid(s0_valid), .s0_result(s0_result), .s0_ok(s0_ok),
    .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
    .s1_valid(s1_valid), .s1_result(s1_result), .s1_ok(s1_ok),
    .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
    .invtlb_asid(invtlb_asid), .invtlb_va(invtlb_va),
    .we(we), .w_index(w_index), .w_entry(w_entry),
    .r_index(r_index), .r_entry(r_entry)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters and scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [RW-1:0] exp_q0[$];
  logic [RW-1:0] exp_q1[$];
  int epoch = 0;
  int last_ep0 = -1, last_ep1 = -1;
  bit prev_ok0 = 0, prev_ok1 = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  tlb_entry_t model_mem [16];
  bit          tag_v [2];
  logic [29:0] tag_k [2];

  function automatic bit page_match(input tlb_entry_t m, input logic [18:0] vp);
    if (m.ps == 6'd21) return m.vppn[18:9] == vp[18:9];
    return m.vppn == vp;
  endfunction

  function automatic tlb_result_t model_search(input logic [18:0] vp, input logic b12,
                                               input logic [9:0] asid);
    tlb_result_t r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (model_mem[i].e && (model_mem[i].g || model_mem[i].asid == asid) &&
          page_match(model_mem[i], vp)) begin
        bit odd;
        odd = (model_mem[i].ps == 6'd21) ? vp[8] : b12;
        r.found = 1'b1;
        r.index = 4'(i);
        r.ps    = model_mem[i].ps;
        r.ppn   = odd ? model_mem[i].ppn1 : model_mem[i].ppn0;
        r.plv   = odd ? model_mem[i].plv1 : model_mem[i].plv0;
        r.mat   = odd ? model_mem[i].mat1 : model_mem[i].mat0;
        r.d     = odd ? model_mem[i].d1   : model_mem[i].d0;
        r.v     = odd ? model_mem[i].v1   : model_mem[i].v0;
        return r;
      end
    end
    return r;
  endfunction

  function automatic void model_update(input bit do_we, input int idx, input tlb_entry_t ent,
                                       input bit do_inv, input int op, input logic [9:0] asid,
                                       input logic [31:0] va);
    for (int i = 0; i < 16; i++) begin
      if (do_we && i == idx) model_mem[i] = ent;
      else if (do_inv) begin
        bit g, a_eq, v_eq, kill;
        g    = model_mem[i].g;
        a_eq = (model_mem[i].asid == asid);
        v_eq = page_match(model_mem[i], va[31:13]);
        case (op)
          0, 1:    kill = 1;
          2:       kill = g;
          3:       kill = !g;
          4:       kill = !g && a_eq;
          5:       kill = !g && a_eq && v_eq;
          6:       kill = (g || a_eq) && v_eq;
          default: kill = 0;
        endcase
        if (kill) model_mem[i].e = 1'b0;
      end
    end
    tag_v[0] = 0;
    tag_v[1] = 0;
  endfunction

  // ---------------- monitor ----------------
  // Pops one expected result each time a port starts presenting ok, or when
  // the array changed under a held request.
  always @(negedge clk) begin
    if (!reset && s0_valid && s0_ok && (!prev_ok0 || epoch != last_ep0)) begin
      if (exp_q0.size() == 0) chk("s0 unexpected ok", 1, 0);
      else chk("s0 result", s0_result, exp_q0.pop_front());
      last_ep0 = epoch;
    end
    prev_ok0 = !reset && s0_valid && s0_ok;
    if (!reset && s1_valid && s1_ok && (!prev_ok1 || epoch != last_ep1)) begin
      if (exp_q1.size() == 0) chk("s1 unexpected ok", 1, 0);
      else chk("s1 result", s1_result, exp_q1.pop_front());
      last_ep1 = epoch;
    end
    prev_ok1 = !reset && s1_valid && s1_ok;
  end

  // ---------------- driver tasks ----------------
  task automatic set_port(input int p, input logic v, input logic [18:0] vp, input logic b,
                          input logic [9:0] a);
    if (p == 0) begin
      s0_valid = v; s0_vppn = vp; s0_va_bit12 = b; s0_asid = a;
    end else begin
      s1_valid = v; s1_vppn = vp; s1_va_bit12 = b; s1_asid = a;
    end
  endtask

  task automatic push_exp(input int p, input tlb_result_t r);
    if (p == 0) exp_q0.push_back(r);
    else        exp_q1.push_back(r);
  endtask

  // Present a request; returns the latency the model expects.
  task automatic start_search(input int p, input logic [18:0] vp, input logic b,
                              input logic [9:0] a, output int exp_lat);
    logic [29:0] key;
    key = {vp, b, a};
    exp_lat = (REG_MODE && !(tag_v[p] && tag_k[p] == key)) ? 1 : 0;
    push_exp(p, model_search(vp, b, a));
    @(posedge clk); #1;
    set_port(p, 1'b1, vp, b, a);
    tag_v[p] = 1;
    tag_k[p] = key;
  endtask

  task automatic wait_ok(input int p, input int exp_lat);
    int  lat;
    bit  got;
    lat = 0;
    got = 0;
    for (int c = 0; c < 6 && !got; c++) begin
      @(negedge clk);
      if ((p == 0) ? s0_ok : s1_ok) got = 1;
      else lat++;
    end
    if (!got) begin
      chk($sformatf("s%0d ok timeout", p), 0, 1);
      if (p == 0) void'(exp_q0.pop_back());
      else        void'(exp_q1.pop_back());
    end else begin
      chk($sformatf("s%0d latency", p), lat, exp_lat);
    end
  endtask

  task automatic do_search(input int p, input logic [18:0] vp, input logic b,
                           input logic [9:0] a);
    int el;
    start_search(p, vp, b, a, el);
    wait_ok(p, el);
    @(posedge clk); #1;
    set_port(p, 1'b0, vp, b, a);
  endtask

  // One-cycle write and/or INVTLB pulse, with a no-bypass read check.
  task automatic drive_cmd(input bit do_we, input int idx, input tlb_entry_t ent,
                           input bit do_inv, input int op, input logic [9:0] asid,
                           input logic [31:0] va);
    @(posedge clk); #1;
    we = do_we; w_index = 4'(idx); w_entry = ent;
    invtlb_valid = do_inv; invtlb_op = 5'(op); invtlb_asid = asid; invtlb_va = va;
    r_index = 4'(idx);
    #1;
    if (do_we) chk("r_entry before write", r_entry, model_mem[idx]);
    @(posedge clk);
    model_update(do_we, idx, ent, do_inv, op, asid, va);
    epoch++;
    #1;
    we = 0; invtlb_valid = 0;
    #1;
    if (do_we) chk("r_entry after write", r_entry, model_mem[idx]);
  endtask

  function automatic tlb_entry_t rand_entry(input logic [18:0] vp);
    tlb_entry_t t;
    t.e    = ($urandom_range(0, 3) != 0);
    t.vppn = vp;
    t.ps   = ($urandom_range(0, 1) != 0) ? 6'd21 : 6'd12;
    t.g    = ($urandom_range(0, 2) == 0);
    t.asid = 10'($urandom_range(1, 3));
    t.ppn0 = 20'($urandom); t.plv0 = 2'($urandom); t.mat0 = 2'($urandom);
    t.d0   = 1'($urandom);  t.v0   = 1'($urandom);
    t.ppn1 = 20'($urandom); t.plv1 = 2'($urandom); t.mat1 = 2'($urandom);
    t.d1   = 1'($urandom);  t.v1   = 1'($urandom);
    return t;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main stimulus ----------------
  initial begin
    tlb_entry_t a, b;
    logic [18:0] pool [4];
    int el;
    pool[0] = 19'h00100; pool[1] = 19'h00300; pool[2] = 19'h7f000; pool[3] = 19'h12345;

    reset = 1; we = 0; invtlb_valid = 0; invtlb_op = 0; invtlb_asid = 0; invtlb_va = 0;
    w_index = 0; w_entry = '0; r_index = 0;
    set_port(0, 1'b0, 19'h0, 1'b0, 10'h0);
    set_port(1, 1'b0, 19'h0, 1'b0, 10'h0);
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    tag_v[0] = 0; tag_v[1] = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;

    // Reset state.
    @(negedge clk);
    chk("reset s0_ok", s0_ok, 0);
    chk("reset s1_ok", s1_ok, 0);
    chk("reset s0_result", s0_result, 0);
    chk("reset s1_result", s1_result, 0);
    chk("reset r_entry", r_entry, 0);

    // Write idx 3 (4 KB page) and hit it on port 0, odd page.
    a = '0;
    a.e = 1; a.vppn = 19'h12345; a.ps = 6'd12; a.g = 0; a.asid = 10'd5;
    a.ppn0 = 20'hAAAAA; a.plv0 = 2'd1; a.mat0 = 2'd1; a.d0 = 1; a.v0 = 1;
    a.ppn1 = 20'hBBBBB; a.plv1 = 2'd3; a.mat1 = 2'd2; a.d1 = 0; a.v1 = 1;
    drive_cmd(1, 3, a, 0, 0, 0, 0);
    do_search(0, 19'h12345, 1'b1, 10'd5);
    do_search(0, 19'h12345, 1'b0, 10'd5);
    do_search(0, 19'h12345, 1'b1, 10'd6);

    // 2 MB global page at idx 7, port 1 with vppn[8]=1.
    b = '0;
    b.e = 1; b.vppn = 19'h12200; b.ps = 6'd21; b.g = 1; b.asid = 10'd0;
    b.ppn0 = 20'h11111; b.plv0 = 2'd0; b.mat0 = 2'd1; b.d0 = 0; b.v0 = 1;
    b.ppn1 = 20'h22222; b.plv1 = 2'd2; b.mat1 = 2'd0; b.d1 = 1; b.v1 = 1;
    drive_cmd(1, 7, b, 0, 0, 0, 0);
    do_search(1, 19'h12300, 1'b0, 10'd9);
    do_search(1, 19'h12000, 1'b1, 10'd9);

    // Hold a hit on idx 3, then INVTLB op 4 asid 5 underneath it.
    start_search(0, 19'h12345, 1'b1, 10'd5, el);
    wait_ok(0, el);
    drive_cmd(0, 0, '0, 1, 4, 10'd5, 32'h0);
    push_exp(0, model_search(19'h12345, 1'b1, 10'd5));
    @(negedge clk);
    chk("s0 ok gap after invtlb", s0_ok, REG_MODE ? 0 : 1);
    wait_ok(0, 0);
    tag_v[0] = 1;
    @(posedge clk); #1;
    set_port(0, 1'b0, 19'h12345, 1'b1, 10'd5);

    // Multi-hit: identical entries at 2 and 9, lowest wins; then write 9 with INVTLB op 0.
    a = '0;
    a.e = 1; a.vppn = 19'h05555; a.ps = 6'd12; a.g = 1; a.asid = 10'd1;
    a.ppn0 = 20'h33333; a.ppn1 = 20'h44444; a.v0 = 1; a.v1 = 1;
    drive_cmd(1, 2, a, 0, 0, 0, 0);
    drive_cmd(1, 9, a, 0, 0, 0, 0);
    do_search(1, 19'h05555, 1'b0, 10'd2);
    drive_cmd(1, 9, a, 1, 0, 0, 0);
    do_search(1, 19'h05555, 1'b0, 10'd2);
    do_search(0, 19'h12300, 1'b1, 10'd9);

    // Randomized traffic.
    for (int it = 0; it < 80; it++) begin
      int act;
      act = $urandom_range(0, 9);
      if (act < 3) begin
        logic [18:0] vp;
        vp = pool[$urandom_range(0, 3)] ^ 19'($urandom_range(0, 1));
        drive_cmd(1, $urandom_range(0, 15), rand_entry(vp), (act == 0),
                  $urandom_range(0, 7), 10'($urandom_range(1, 3)),
                  {pool[$urandom_range(0, 3)], 13'($urandom)});
      end else if (act == 3) begin
        drive_cmd(0, 0, '0, 1, $urandom_range(0, 7), 10'($urandom_range(1, 3)),
                  {pool[$urandom_range(0, 3)] ^ 19'($urandom_range(0, 1)), 13'($urandom)});
      end else begin
        logic [18:0] vp;
        vp = pool[$urandom_range(0, 3)] ^ 19'($urandom_range(0, 1)) ^
             (($urandom_range(0, 1) != 0) ? 19'h00100 : 19'h0);
        do_search($urandom_range(0, 1), vp, 1'($urandom), 10'($urandom_range(1, 3)));
      end
    end

    // Reset while port 1 is waiting.
    @(posedge clk); #1;
    set_port(1, 1'b1, 19'h12300, 1'b0, 10'd9);
    reset = 1;
    @(posedge clk);
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    tag_v[0] = 0; tag_v[1] = 0;
    epoch++;
    #1 reset = 0;
    push_exp(1, model_search(19'h12300, 1'b0, 10'd9));
    @(negedge clk);
    chk("s1 ok after reset", s1_ok, REG_MODE ? 0 : 1);
    wait_ok(1, 0);
    @(posedge clk); #1;
    set_port(1, 1'b0, 19'h12300, 1'b0, 10'd9);
    for (int i = 0; i < 16; i++) begin
      r_index = 4'(i);
      #1;
      chk($sformatf("r_entry[%0d] after reset", i), r_entry, 0);
    end

    repeat (3) @(negedge clk);
    chk("expected queues drained", exp_q0.size() + exp_q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
